uart_cmd_sequencer: RTL and testbench

//  Queues command bytes (e.g. 'G'=0x47 start, 'S'=0x53 stop) and issues them to the UART

---
 rtl/uart_cmd_sequencer_if.sv | 46 ++++
 rtl/uart_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if
// Bundles the command-producer side, the UART_tx handshake and the status/error signals of
// uart_cmd_sequencer.
// Modports:
//   slave  - the sequencer itself (drives full/empty/count/trmt/tx_data/busy/errors)
//   master - the environment (drives push/push_data/tx_done/clr_err)
// Build option: CMD_SEQ_STATS_EN adds the sent_cnt/drop_cnt statistics counters.
interface uart_cmd_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              empty;
    logic [CntW-1:0]   count;
    logic              trmt;
    logic [DATA_W-1:0] tx_data;
    logic              tx_done;
    logic              busy;
    logic              ovf_err;
    logic              timeout_err;
    logic              clr_err;
`ifdef CMD_SEQ_STATS_EN
    logic [15:0]       sent_cnt;
    logic [15:0]       drop_cnt;
`endif

    modport slave (
        input  push, push_data, tx_done, clr_err,
        output full, empty, count, trmt, tx_data, busy, ovf_err, timeout_err
`ifdef CMD_SEQ_STATS_EN
        , output sent_cnt, drop_cnt
`endif
    );

    modport master (
        output push, push_data, tx_done, clr_err,
        input  full, empty, count, trmt, tx_data, busy, ovf_err, timeout_err
`ifdef CMD_SEQ_STATS_EN
        , input sent_cnt, drop_cnt
`endif
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
// Queues command bytes in a small FIFO and issues them one at a time to UART_tx over the
// trmt/tx_data/tx_done handshake. Every completed send is followed by a GAP_CYC-clock idle gap;
// a transmitter that never answers is caught by a watchdog, which halts issuing until clr_err.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset (drops any in-flight byte and the FIFO contents)
//   bus    uart_cmd_sequencer_if.slave:
//            push/push_data in, full/empty/count out        - producer side
//            trmt/tx_data out, tx_done in                   - UART_tx side
//            busy/ovf_err/timeout_err out, clr_err in       - status and sticky errors
// Build option: define CMD_SEQ_STATS_EN to add saturating bus.sent_cnt / bus.drop_cnt.
module uart_cmd_sequencer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned GAP_CYC     = 50,
    parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_cmd_sequencer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GapW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYC - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitDone,
        StGap,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              trmt_q, trmt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic              timeout_q, timeout_d;
    logic [WdW-1:0]    wd_q, wd_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              wr_en;
    logic              rd_en;

    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        trmt_d    = 1'b0;
        tx_data_d = tx_data_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;

        // Full is the registered flag, so a push alongside a pop while full is still dropped.
        wr_en = bus.push && !full_q;

        // Clear first so that a coincident new error wins over clr_err.
        if (bus.clr_err) begin
            ovf_d     = 1'b0;
            timeout_d = 1'b0;
        end
        if (bus.push && full_q) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    rd_en     = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    trmt_d    = 1'b1;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                // tx_done is not looked at here; it cannot belong to this byte yet.
                wd_d    = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (bus.tx_done) begin
                    gap_d   = '0;
                    state_d = (GAP_CYC == 0) ? StIdle : StGap;
                end else if (wd_q == WdLast) begin
                    timeout_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StHalt: begin
                if (bus.clr_err) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CntFull);
        empty_d = (count_d == '0);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            trmt_q    <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            trmt_q    <= trmt_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            gap_q     <= gap_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.push_data;
        end
    end

    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.count       = count_q;
    assign bus.trmt        = trmt_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = busy_q;
    assign bus.ovf_err     = ovf_q;
    assign bus.timeout_err = timeout_q;

`ifdef CMD_SEQ_STATS_EN
    logic        sent_inc;
    logic        to_inc;
    logic        ovf_inc;
    logic [16:0] drop_sum;
    logic [15:0] sent_q, sent_d;
    logic [15:0] drop_q, drop_d;

    always_comb begin
        sent_inc = (state_q == StWaitDone) && bus.tx_done;
        to_inc   = (state_q == StWaitDone) && !bus.tx_done && (wd_q == WdLast);
        ovf_inc  = bus.push && full_q;
        sent_d   = (sent_inc && (sent_q != 16'hFFFF)) ? sent_q + 16'd1 : sent_q;
        // A drop and a timeout can land in the same cycle, so add up to two.
        drop_sum = {1'b0, drop_q} + {16'd0, to_inc} + {16'd0, ovf_inc};
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sent_q <= '0;
            drop_q <= '0;
        end else begin
            sent_q <= sent_d;
            drop_q <= drop_d;
        end
    end

    assign bus.sent_cnt = sent_q;
    assign bus.drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer
// Self-checking bench for uart_cmd_sequencer with a short gap and watchdog so that every
// scenario fits in a few thousand clocks. Inputs are driven 1 time unit after the rising edge
// and outputs are sampled at the same point, so a value seen after step() is the state the
// DUT registered on that edge.
module tb_uart_cmd_sequencer;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned DEPTH       = 8;
    localparam int unsigned GAP_CYC     = 4;
    localparam int unsigned TIMEOUT_CYC = 100;
    localparam int unsigned CntW        = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    uart_cmd_sequencer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    uart_cmd_sequencer #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .GAP_CYC    (GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
    endtask

    // Steps until trmt is seen; n is the number of steps taken.
    task automatic wait_trmt(input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            step();
            n++;
            if (bus.trmt) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (bus.busy && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] st;
        bus.push = 1'b0; bus.push_data = '0; bus.tx_done = 1'b0; bus.clr_err = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        st = {bus.empty, bus.full, bus.trmt, bus.busy, bus.ovf_err, bus.timeout_err, 2'b00};
        total++;
        if (st !== 8'b1000_0000) begin
            bad++; $display("FAIL reset_flags got %b want %b", st, 8'b1000_0000);
        end
        total++;
        if (bus.count !== '0 || bus.tx_data !== '0) begin
            bad++; $display("FAIL reset_regs got count=%0d tx_data=%h want 0/00", bus.count, bus.tx_data);
        end
`ifdef CMD_SEQ_STATS_EN
        total++;
        if (bus.sent_cnt !== 16'd0 || bus.drop_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_stats got %0d/%0d want 0/0", bus.sent_cnt, bus.drop_cnt);
        end
`endif
    endtask

    task automatic test_single();
        int pulses = 0;
        int n;
        bus.push = 1'b1; bus.push_data = 8'h47;
        step();
        bus.push = 1'b0;
        total++;
        if (bus.count !== CntW'(1) || bus.empty !== 1'b0 || bus.busy !== 1'b0 || bus.trmt !== 1'b0) begin
            bad++; $display("FAIL single_queued got count=%0d empty=%b busy=%b trmt=%b want 1/0/0/0",
                            bus.count, bus.empty, bus.busy, bus.trmt);
        end
        step();
        total++;
        if (bus.trmt !== 1'b1 || bus.tx_data !== 8'h47 || bus.busy !== 1'b1 || bus.count !== '0) begin
            bad++; $display("FAIL single_issue got trmt=%b data=%h busy=%b count=%0d want 1/47/1/0",
                            bus.trmt, bus.tx_data, bus.busy, bus.count);
        end
        pulses = 1;
        // A tx_done while trmt is still high belongs to nothing and must be ignored.
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        if (bus.trmt) pulses++;
        for (int i = 0; i < 18; i++) begin
            step();
            if (bus.trmt) pulses++;
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL single_load_done_ignored got busy=%b want 1", bus.busy);
        end
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        n = 1;
        while (bus.busy && n < 200) begin
            step();
            n++;
            if (bus.trmt) pulses++;
        end
        total++;
        if (n !== GAP_CYC + 1) begin
            bad++; $display("FAIL single_busy_fall got %0d clk want %0d", n, GAP_CYC + 1);
        end
        total++;
        if (pulses !== 1 || bus.tx_data !== 8'h47) begin
            bad++; $display("FAIL single_pulse got pulses=%0d data=%h want 1/47", pulses, bus.tx_data);
        end
`ifdef CMD_SEQ_STATS_EN
        total++;
        if (bus.sent_cnt !== 16'd1) begin
            bad++; $display("FAIL single_sent_cnt got %0d want 1", bus.sent_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  ok;
        bus.push = 1'b1; bus.push_data = 8'h47;
        step();
        bus.push_data = 8'h53;
        step();
        bus.push = 1'b0;
        total++;
        if (bus.trmt !== 1'b1 || bus.tx_data !== 8'h47) begin
            bad++; $display("FAIL b2b_first got trmt=%b data=%h want 1/47", bus.trmt, bus.tx_data);
        end
        for (int i = 0; i < 5; i++) step();
        bus.tx_done = 1'b1;
        wait_trmt(100, n, ok);
        bus.tx_done = 1'b0;
        total++;
        if (!ok || n !== GAP_CYC + 2) begin
            bad++; $display("FAIL b2b_spacing got %0d clk (seen=%0d) want %0d", n, ok, GAP_CYC + 2);
        end
        total++;
        if (bus.tx_data !== 8'h53) begin
            bad++; $display("FAIL b2b_second got %h want 53", bus.tx_data);
        end
        step(); step(); step();
        pulse_done();
        wait_idle(100, n);
    endtask

    task automatic test_overflow();
        int         n;
        bit         ok;
        logic [7:0] d;
        bus.push = 1'b1; bus.push_data = 8'hA0;
        step();
        bus.push = 1'b0;
        step();
        total++;
        if (bus.trmt !== 1'b1 || bus.tx_data !== 8'hA0) begin
            bad++; $display("FAIL ovf_lead got trmt=%b data=%h want 1/a0", bus.trmt, bus.tx_data);
        end
        for (int i = 0; i < 9; i++) begin
            bus.push = 1'b1; bus.push_data = 8'(16 + i);
            step();
        end
        bus.push = 1'b0;
        total++;
        if (bus.full !== 1'b1 || bus.count !== CntW'(DEPTH) || bus.ovf_err !== 1'b1) begin
            bad++; $display("FAIL ovf_fill got full=%b count=%0d ovf=%b want 1/%0d/1",
                            bus.full, bus.count, bus.ovf_err, DEPTH);
        end
        // clr_err together with a fresh overflow leaves the error set.
        bus.push = 1'b1; bus.push_data = 8'hEE; bus.clr_err = 1'b1;
        step();
        bus.push = 1'b0; bus.clr_err = 1'b0;
        total++;
        if (bus.ovf_err !== 1'b1 || bus.count !== CntW'(DEPTH)) begin
            bad++; $display("FAIL ovf_clr_race got ovf=%b count=%0d want 1/%0d", bus.ovf_err, bus.count, DEPTH);
        end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        total++;
        if (bus.ovf_err !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL ovf_clear got ovf=%b busy=%b want 0/1", bus.ovf_err, bus.busy);
        end
        pulse_done();
        for (int k = 0; k < DEPTH; k++) begin
            wait_trmt(50, n, ok);
            d = 8'(16 + k);
            total++;
            if (!ok || bus.tx_data !== d) begin
                bad++; $display("FAIL ovf_drain[%0d] got %h (seen=%0d) want %h", k, bus.tx_data, ok, d);
            end
            step(); step();
            pulse_done();
        end
        wait_trmt(30, n, ok);
        total++;
        if (ok || bus.empty !== 1'b1) begin
            bad++; $display("FAIL ovf_ninth_sent got trmt_seen=%0d empty=%b want 0/1", ok, bus.empty);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        bus.push = 1'b1; bus.push_data = 8'h5A;
        step();
        bus.push = 1'b0;
        step();
        n = 0;
        while (!bus.timeout_err && n < 300) begin
            step();
            n++;
        end
        total++;
        if (n !== TIMEOUT_CYC + 1) begin
            bad++; $display("FAIL timeout_latency got %0d clk want %0d", n, TIMEOUT_CYC + 1);
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL timeout_halt got busy=%b want 1", bus.busy);
        end
        bus.push = 1'b1; bus.push_data = 8'h6B;
        step();
        bus.push = 1'b0;
        wait_trmt(10, n, ok);
        total++;
        if (ok || bus.count !== CntW'(1) || bus.timeout_err !== 1'b1) begin
            bad++; $display("FAIL timeout_hold got trmt_seen=%0d count=%0d err=%b want 0/1/1",
                            ok, bus.count, bus.timeout_err);
        end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        total++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL timeout_clear got err=%b busy=%b want 0/0", bus.timeout_err, bus.busy);
        end
        step();
        total++;
        if (bus.trmt !== 1'b1 || bus.tx_data !== 8'h6B) begin
            bad++; $display("FAIL timeout_resume got trmt=%b data=%h want 1/6b", bus.trmt, bus.tx_data);
        end
        step(); step();
        pulse_done();
        wait_idle(100, n);
    endtask

    task automatic test_expiry_race();
        int n;
        bus.push = 1'b1; bus.push_data = 8'h33;
        step();
        bus.push = 1'b0;
        step();
        for (int i = 0; i < TIMEOUT_CYC; i++) step();
        total++;
        if (bus.timeout_err !== 1'b0) begin
            bad++; $display("FAIL race_early got err=%b want 0", bus.timeout_err);
        end
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        total++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL race_done_wins got err=%b busy=%b want 0/1", bus.timeout_err, bus.busy);
        end
        n = 1;
        while (bus.busy && n < 100) begin
            step();
            n++;
        end
        total++;
        if (n !== GAP_CYC + 1) begin
            bad++; $display("FAIL race_gap got %0d clk want %0d", n, GAP_CYC + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            bus.push = 1'b1; bus.push_data = 8'(8'h81 + i);
            step();
        end
        bus.push = 1'b0;
        step(); step(); step();
        total++;
        if (bus.count !== CntW'(3) || bus.busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre got count=%0d busy=%b want 3/1", bus.count, bus.busy);
        end
        rst_n = 1'b0;
        step();
        total++;
        if (bus.empty !== 1'b1 || bus.count !== '0 || bus.trmt !== 1'b0 || bus.busy !== 1'b0 ||
            bus.tx_data !== '0) begin
            bad++; $display("FAIL rstmid_state got empty=%b count=%0d trmt=%b busy=%b data=%h want 1/0/0/0/00",
                            bus.empty, bus.count, bus.trmt, bus.busy, bus.tx_data);
        end
`ifdef CMD_SEQ_STATS_EN
        total++;
        if (bus.sent_cnt !== 16'd0) begin
            bad++; $display("FAIL rstmid_sent_cnt got %0d want 0", bus.sent_cnt);
        end
`endif
        rst_n = 1'b1;
        wait_trmt(10, n, ok);
        total++;
        if (ok) begin
            bad++; $display("FAIL rstmid_quiet got trmt_seen=%0d want 0", ok);
        end
    endtask

    // Random pushes and random UART response delays. The model only knows that bytes leave in
    // push order, that each trmt is the moment one byte leaves the queue, and that occupancy is
    // therefore pushes minus trmt pulses.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] want;
        int         pushed = 0;
        int         seen = 0;
        int         d = -1;
        int         cyc = 0;
        int         n;
        logic       prev_trmt = 1'b0;
        while ((pushed < 40 || seen < pushed || d >= 0) && cyc < 6000) begin
            step();
            cyc++;
            bus.push = 1'b0;
            bus.tx_done = 1'b0;
            if (d > 0) begin
                d--;
                if (d == 0) begin
                    bus.tx_done = 1'b1;
                    d = -1;
                end
            end
            if (bus.trmt) begin
                seen++;
                total++;
                if (prev_trmt || exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_trmt_pulse got trmt repeat=%b queued=%0d want single pulse with data",
                                    prev_trmt, exp_q.size());
                end else begin
                    want = exp_q.pop_front();
                    if (bus.tx_data !== want) begin
                        bad++; $display("FAIL rand_order got %h want %h", bus.tx_data, want);
                    end
                end
                d = $urandom_range(1, 12);
            end
            prev_trmt = bus.trmt;
            total++;
            if (bus.count !== CntW'(pushed - seen) || bus.ovf_err !== 1'b0) begin
                bad++; $display("FAIL rand_count got count=%0d ovf=%b want %0d/0",
                                bus.count, bus.ovf_err, pushed - seen);
            end
            if (pushed < 40 && (pushed - seen) < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
                bus.push = 1'b1;
                bus.push_data = 8'($urandom);
                exp_q.push_back(bus.push_data);
                pushed++;
            end
        end
        step();
        bus.push = 1'b0;
        bus.tx_done = 1'b0;
        wait_idle(200, n);
        total++;
        if (cyc >= 6000 || seen !== 40 || bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rand_drain got cycles=%0d sent=%0d empty=%b busy=%b want <6000/40/1/0",
                            cyc, seen, bus.empty, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_expiry_race();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
